// File: rtl/red_secuencial_izq_der.sv
// Sequential MSB-first unsigned magnitude comparator: one bit pair per clock, N SCAN cycles, done pulse.
// Shares the 2-bit GT/LT/EQ cell encoding of the combinational right-to-left network.
module red_secuencial_izq_der #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         Zout,
    output logic         eq,
    output logic         lt
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_SCAN = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [1:0] P_EQ = 2'b00;
    localparam logic [1:0] P_LT = 2'b01;
    localparam logic [1:0] P_GT = 2'b10;

    logic [1:0]    state;
    logic [N-1:0]  ar;
    logic [N-1:0]  br;
    logic [CW-1:0] cnt;
    logic [1:0]    p;
    logic [1:0]    p_next;

    // Operands shift left, so the bit under examination is always the MSB.
    // Once decided, p sticks; 2'b11 is unreachable and behaves as EQ.
    always_comb begin
        p_next = p;
        if (p != P_GT && p != P_LT) begin
            if (ar[N-1] && !br[N-1]) begin
                p_next = P_GT;
            end else if (!ar[N-1] && br[N-1]) begin
                p_next = P_LT;
            end else begin
                p_next = P_EQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            ar    <= '0;
            br    <= '0;
            cnt   <= '0;
            p     <= P_EQ;
            Zout  <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ar    <= A;
                        br    <= B;
                        cnt   <= CW'(N - 1);
                        p     <= P_EQ;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    p   <= p_next;
                    ar  <= ar << 1;
                    br  <= br << 1;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        Zout  <= (p_next == P_GT);
                        lt    <= (p_next == P_LT);
                        eq    <= (p_next != P_GT) && (p_next != P_LT);
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == S_SCAN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_red_secuencial_izq_der.sv
// Bench for red_secuencial_izq_der at N=3 and N=8, checked against plain unsigned comparison.
module tb_red_secuencial_izq_der;

    logic clk = 1'b0;
    logic reset;

    logic       start3;
    logic [2:0] a3, b3;
    logic       busy3, done3, z3, eq3, lt3;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, z8, eq8, lt8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    red_secuencial_izq_der #(.N(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .A(a3), .B(b3),
        .busy(busy3), .done(done3), .Zout(z3), .eq(eq3), .lt(lt3)
    );

    red_secuencial_izq_der #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Zout(z8), .eq(eq8), .lt(lt8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start pulse on the N=3 instance; reports busy count, done cycle and the result at done.
    task automatic run3(input logic [2:0] a, input logic [2:0] b,
                        output int busy_cyc, output int done_at, output logic [2:0] res);
        a3 = a; b3 = b; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        busy_cyc = 0; done_at = -1; res = 3'b000;
        for (int c = 1; c <= 20; c++) begin
            if (busy3) busy_cyc++;
            if (done3) begin
                done_at = c;
                res = {z3, eq3, lt3};
                tick();
                break;
            end
            tick();
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output int busy_cyc, output int done_at, output logic [2:0] res);
        a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        busy_cyc = 0; done_at = -1; res = 3'b000;
        for (int c = 1; c <= 20; c++) begin
            if (busy8) busy_cyc++;
            if (done8) begin
                done_at = c;
                res = {z8, eq8, lt8};
                tick();
                break;
            end
            tick();
        end
    endtask

    function automatic logic [2:0] model(input longint unsigned a, input longint unsigned b);
        return {a > b, a == b, a < b};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start3 = 1'b0; start8 = 1'b0;
        a3 = '0; b3 = '0; a8 = '0; b8 = '0;
        tick(); tick();
        reset = 1'b0;
        total++;
        if ({busy3, done3, z3, eq3, lt3} !== 5'b0) begin
            bad++; $display("FAIL reset3 got=%b want=00000", {busy3, done3, z3, eq3, lt3});
        end
        total++;
        if ({busy8, done8, z8, eq8, lt8} !== 5'b0) begin
            bad++; $display("FAIL reset8 got=%b want=00000", {busy8, done8, z8, eq8, lt8});
        end
    endtask

    task automatic test_gt();
        int bc, da; logic [2:0] r;
        run3(3'b010, 3'b000, bc, da, r);
        total++;
        if (bc !== 3) begin bad++; $display("FAIL gt_busy got=%0d want=3", bc); end
        total++;
        if (da !== 4) begin bad++; $display("FAIL gt_done_cycle got=%0d want=4", da); end
        total++;
        if (r !== 3'b100) begin bad++; $display("FAIL gt_result got=%b want=100", r); end
    endtask

    task automatic test_lt_msb();
        int bc, da; logic [2:0] r;
        run3(3'b011, 3'b100, bc, da, r);
        total++;
        if (r !== 3'b001) begin bad++; $display("FAIL lt_msb got=%b want=001", r); end
    endtask

    task automatic test_eq_held();
        int bc, da; logic [2:0] r;
        int dones[$];
        int stable_bad;
        run3(3'b101, 3'b101, bc, da, r);
        total++;
        if (r !== 3'b010) begin bad++; $display("FAIL eq_single got=%b want=010", r); end
        // start held high continuously: a done every N+2 cycles
        a3 = 3'b101; b3 = 3'b101; start3 = 1'b1;
        stable_bad = 0;
        for (int c = 0; c < 22; c++) begin
            tick();
            if (done3) dones.push_back(c);
            if ({z3, eq3, lt3} !== 3'b010) stable_bad++;
        end
        start3 = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
        total++;
        if (dones.size() < 4) begin
            bad++; $display("FAIL eq_held_count got=%0d want>=4", dones.size());
        end else begin
            for (int i = 1; i < dones.size(); i++) begin
                total++;
                if (dones[i] - dones[i-1] !== 5) begin
                    bad++; $display("FAIL eq_held_period got=%0d want=5", dones[i] - dones[i-1]);
                end
            end
        end
        total++;
        if (stable_bad !== 0) begin bad++; $display("FAIL eq_held_stable got=%0d want=0", stable_bad); end
    endtask

    task automatic test_ignored_start();
        int ndone, late_busy;
        logic [2:0] r;
        a3 = 3'b111; b3 = 3'b000; start3 = 1'b1;
        tick();
        a3 = 3'b000;
        ndone = 0; late_busy = 0; r = 3'b000;
        for (int c = 1; c <= 10; c++) begin
            if (done3) begin ndone++; r = {z3, eq3, lt3}; end
            if (c >= 5 && busy3) late_busy++;
            start3 = (c <= 4);
            tick();
        end
        start3 = 1'b0;
        total++;
        if (ndone !== 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", ndone); end
        total++;
        if (r !== 3'b100) begin bad++; $display("FAIL ign_result got=%b want=100", r); end
        total++;
        if (late_busy !== 0) begin bad++; $display("FAIL ign_busy got=%0d want=0", late_busy); end
    endtask

    task automatic test_reset_mid_scan();
        int ndone, bc, da; logic [2:0] r;
        a3 = 3'b110; b3 = 3'b001; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({busy3, done3, z3, eq3, lt3} !== 5'b0) begin
            bad++; $display("FAIL midrst_state got=%b want=00000", {busy3, done3, z3, eq3, lt3});
        end
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done3 || busy3) ndone++;
            tick();
        end
        total++;
        if (ndone !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", ndone); end
        run3(3'b001, 3'b100, bc, da, r);
        total++;
        if (da !== 4 || r !== 3'b001) begin
            bad++; $display("FAIL midrst_fresh got=%0d/%b want=4/001", da, r);
        end
    endtask

    task automatic test_n8();
        int bc, da; logic [2:0] r;
        run8(8'hFF, 8'hFE, bc, da, r);
        total++;
        if (bc !== 8) begin bad++; $display("FAIL n8_busy got=%0d want=8", bc); end
        total++;
        if (da !== 9) begin bad++; $display("FAIL n8_done_cycle got=%0d want=9", da); end
        total++;
        if (r !== 3'b100) begin bad++; $display("FAIL n8_gt got=%b want=100", r); end
        run8(8'h00, 8'h80, bc, da, r);
        total++;
        if (r !== 3'b001) begin bad++; $display("FAIL n8_lt got=%b want=001", r); end
    endtask

    task automatic test_random();
        int bc, da; logic [2:0] r, exp;
        logic [7:0] a, b;
        logic [2:0] x, y;
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom);
            b = (i % 8 == 0) ? a : 8'($urandom);
            exp = model(longint'(a), longint'(b));
            run8(a, b, bc, da, r);
            total++;
            if (da !== 9 || r !== exp) begin
                bad++; $display("FAIL rand8 a=%h b=%h got=%0d/%b want=9/%b", a, b, da, r, exp);
            end
        end
        for (int i = 0; i < 40; i++) begin
            x = 3'($urandom);
            y = 3'($urandom);
            exp = model(longint'(x), longint'(y));
            run3(x, y, bc, da, r);
            total++;
            if (da !== 4 || r !== exp) begin
                bad++; $display("FAIL rand3 a=%0d b=%0d got=%0d/%b want=4/%b", x, y, da, r, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_gt();
        test_lt_msb();
        test_eq_held();
        test_ignored_start();
        test_reset_mid_scan();
        test_n8();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/red_secuencial_izq_der.md
Name: red_secuencial_izq_der

Overview:
- Sequential magnitude comparator that processes operand bits left to right (MSB first), one bit pair per clock.
- It is the clocked, opposite-direction counterpart of the combinational right-to-left iterative comparator network.
- It reuses the same 2-bit cell state encoding for GT/LT/EQ, so the two implementations can be cross-checked against each other in the same bench.
- It is intended for wide operands where a combinational chain is too slow or too large.

Parameters:
- N, 3, operand width in bits; legal range N >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a comparison; sampled only in IDLE.
- A  input  N  operand A; captured on the accepted start.
- B  input  N  operand B; captured on the accepted start.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse; result is valid.
- Zout  output  1  registered result, 1 when A > B (unsigned).
- eq  output  1  registered result, 1 when A == B.
- lt  output  1  registered result, 1 when A < B.

Behaviour:
- Reset: clk and reset only, with reset synchronous and active-high.
  - State goes to IDLE; shift registers and bit counter clear.
  - busy=0, done=0, Zout=0, eq=0, lt=0.
  - Reset has priority over every other event, including mid-SCAN: the comparison is aborted and no done is produced.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at edge k: capture A and B into shift registers, set counter to N-1, set cell state p=EQ (2'b00), go to SCAN.
  - start=0: stay in IDLE.
- SCAN:
  - Each edge examines bit pair (Ar[cnt], Br[cnt]) with cnt counting N-1 down to 0.
  - Cell rule, left to right:
    - If p==EQ: Ai>Bi gives GT (2'b10), Ai<Bi gives LT (2'b01), otherwise EQ.
    - If p==GT or p==LT, p holds; later bits are ignored.
  - Latency is always exactly N SCAN cycles. There is no early exit, so timing is data-independent.
  - When cnt==0 is processed (edge k+N), load Zout/eq/lt from the final p, assert done, go to DONE.
  - busy=1 during all SCAN cycles (after edge k through edge k+N).
- DONE:
  - Lasts one cycle with done=1 and busy=0.
  - The next edge returns to IDLE unconditionally and clears done.
- Result hold: Zout/eq/lt hold their values after DONE until the next accepted start completes. They are not cleared by start itself.
- Ignored starts: start asserted in SCAN or DONE is ignored, not queued. A and B changes after capture have no effect.
- One-hot result: after the first completed comparison, exactly one of Zout/eq/lt is 1. Before that (post-reset), all three are 0.
- N=1: SCAN lasts one cycle; done appears at edge k+1.
- Throughput: one comparison per N+2 cycles when start is held high continuously (IDLE, N×SCAN, DONE).
- Arithmetic: operands are unsigned; there are no width extensions. The counter width is max(1, clog2(N)).
- Encoding: cell state encoding matches the iterative network (EQ=00, LT=01, GT=10; 11 is unreachable and treated as EQ).

Test Plan:
- N=3, A=3'b010, B=3'b000, 1-cycle start pulse:
  - busy high 3 cycles;
  - done pulse in cycle 4 after the start edge;
  - Zout=1, eq=0, lt=0.
- N=3, A=3'b011, B=3'b100:
  - MSB decides LT; lower bits (A greater) ignored;
  - lt=1, Zout=0, eq=0 at done.
- N=3, A=B=3'b101:
  - eq=1 at done;
  - repeat with start held high continuously: done pulses every 5 cycles, result stable between pulses.
- N=3, start A=3'b111, B=3'b000, then pulse start again with A=3'b000 during SCAN and DONE:
  - the second start is ignored;
  - exactly one done, Zout=1;
  - busy never re-asserts until start is seen in IDLE.
- Reset mid-SCAN (cycle 2 of 3):
  - next cycle busy=0, done=0, results=0, state IDLE;
  - no done follows;
  - a fresh start completes normally.
- N=8, A=8'hFF, B=8'hFE:
  - busy 8 cycles, Zout=1 (decided on LSB);
  - then A=8'h00, B=8'h80 gives lt=1;
  - the result matches the combinational right-to-left network for 200 random pairs.
